// File: rtl/axi_pkg.sv
// Shared AXI3 constants and FSM state encodings for the SRAM responder.
package axi_pkg;

  localparam int ID_W  = 4;
  localparam int LEN_W = 8;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic [2:0] R_IDLE = 3'b001;
  localparam logic [2:0] R_REQ  = 3'b010;
  localparam logic [2:0] R_DATA = 3'b100;

  localparam logic [2:0] W_IDLE = 3'b001;
  localparam logic [2:0] W_DATA = 3'b010;
  localparam logic [2:0] W_RESP = 3'b100;

endpackage

// File: rtl/sram_1rw.sv
// Single-port word RAM: synchronous one-cycle read, per-byte write enable.
module sram_1rw #(
  parameter int ADDR_W    = 14,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  // Read-during-write returns the old word, keeping each access word-atomic.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 responder over a single-port SRAM; independent read/write FSMs share the
// RAM port through an alternating-priority arbiter.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter     INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [ID_W-1:0]  arid,
  input  logic [31:0]      araddr,
  input  logic [LEN_W-1:0] arlen,
  input  logic [2:0]       arsize,
  input  logic [1:0]       arburst,
  input  logic [1:0]       arlock,
  input  logic [3:0]       arcache,
  input  logic [2:0]       arprot,
  input  logic             arvalid,
  output logic             arready,
  output logic [ID_W-1:0]  rid,
  output logic [31:0]      rdata,
  output logic [1:0]       rresp,
  output logic             rlast,
  output logic             rvalid,
  input  logic             rready,
  input  logic [ID_W-1:0]  awid,
  input  logic [31:0]      awaddr,
  input  logic [LEN_W-1:0] awlen,
  input  logic [2:0]       awsize,
  input  logic [1:0]       awburst,
  input  logic [1:0]       awlock,
  input  logic [3:0]       awcache,
  input  logic [2:0]       awprot,
  input  logic             awvalid,
  output logic             awready,
  input  logic [ID_W-1:0]  wid,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  input  logic             wlast,
  input  logic             wvalid,
  output logic             wready,
  output logic [ID_W-1:0]  bid,
  output logic [1:0]       bresp,
  output logic             bvalid,
  input  logic             bready
);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [3:0]        r_cnt;
  logic [2:0]        w_state;
  logic [ADDR_W-1:0] w_idx;
  logic [3:0]        w_cnt;

  logic rd_req, wr_req, rd_gnt, wr_gnt;
  logic last_gnt_rd;
  logic rd_vld_p1;

  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_rdata;

  logic unused_inputs;
  assign unused_inputs = ^{araddr[31:ADDR_W+2], araddr[1:0], arlen[7:4], arsize,
                           arburst ^ BURST_INCR, arlock, arcache, arprot,
                           awaddr[31:ADDR_W+2], awaddr[1:0], awlen[7:4], awsize,
                           awburst, awlock, awcache, awprot, wid, wlast};

  // Grants are masked during reset so no beat can land in the reset cycle.
  assign rd_req = (r_state == R_IDLE) ? 1'b0 : (r_state == R_REQ);
  assign wr_req = (w_state == W_DATA) && wvalid;
  assign rd_gnt = resetn && rd_req && (!wr_req || !last_gnt_rd);
  assign wr_gnt = resetn && wr_req && !rd_gnt;

  assign arready = (r_state == R_IDLE);
  assign awready = (w_state == W_IDLE);
  assign wready  = wr_gnt;
  assign bvalid  = (w_state == W_RESP);
  assign rresp   = RESP_OKAY;
  assign bresp   = RESP_OKAY;

  assign ram_addr = wr_gnt ? w_idx : r_idx;

  sram_1rw #(
    .ADDR_W   (ADDR_W),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .en   (rd_gnt || wr_gnt),
    .we   (wr_gnt),
    .be   (wstrb),
    .addr (ram_addr),
    .wdata(wdata),
    .rdata(ram_rdata)
  );

  // Priority flag starts as "read went last" so write wins the first tie.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_gnt_rd <= 1'b1;
    end else if (rd_gnt) begin
      last_gnt_rd <= 1'b1;
    end else if (wr_gnt) begin
      last_gnt_rd <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= R_IDLE;
      rd_vld_p1 <= 1'b0;
      rvalid    <= 1'b0;
      rlast     <= 1'b0;
      rdata     <= 32'h0;
      rid       <= '0;
    end else begin
      rd_vld_p1 <= rd_gnt;
      case (r_state)
        R_IDLE: if (arvalid) begin
          rid     <= arid;
          r_state <= R_REQ;
        end
        R_REQ: if (rd_gnt) r_state <= R_DATA;
        R_DATA: if (rvalid && rready) begin
          rvalid  <= 1'b0;
          rlast   <= 1'b0;
          r_state <= rlast ? R_IDLE : R_REQ;
        end
        default: r_state <= R_IDLE;
      endcase
      // Stage p1: RAM word captured one cycle after its read grant
      if (rd_vld_p1) begin
        rdata  <= ram_rdata;
        rvalid <= 1'b1;
        rlast  <= (r_cnt == 4'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == R_IDLE && arvalid) begin
      r_idx <= araddr[ADDR_W+1:2];
      r_cnt <= arlen[3:0];
    end else if (r_state == R_DATA && rvalid && rready) begin
      r_idx <= r_idx + 1'b1;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_state <= W_IDLE;
      bid     <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (awvalid) begin
          bid     <= awid;
          w_state <= W_DATA;
        end
        W_DATA: if (wvalid && wready && w_cnt == 4'd0) w_state <= W_RESP;
        W_RESP: if (bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_state == W_IDLE && awvalid) begin
      w_idx <= awaddr[ADDR_W+1:2];
      w_cnt <= awlen[3:0];
    end else if (wvalid && wready) begin
      w_idx <= w_idx + 1'b1;
      w_cnt <= w_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized self-checking bench for axi_sram_slave against a word-array memory model.
module tb_axi_sram_slave;

  localparam int AW    = 14;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  arid = '0, awid = '0, wid = '0;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic [7:0]  arlen = '0, awlen = '0;
  logic [2:0]  arsize = '0, awsize = '0, arprot = '0, awprot = '0;
  logic [1:0]  arburst = 2'b01, awburst = 2'b01, arlock = '0, awlock = '0;
  logic [3:0]  arcache = '0, awcache = '0, wstrb = '0;
  logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic        rready = 1'b0, bready = 1'b0;
  logic        arready, awready, wready, rvalid, rlast, bvalid;
  logic [3:0]  rid, bid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  always #5 clk = ~clk;

  axi_sram_slave #(.ADDR_W(AW), .INIT_FILE("")) dut (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] model [int];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] last_rdata;
  int          max_gap, min_gap;

  function automatic int widx(input logic [31:0] addr, input int b);
    return (int'(addr[AW+1:2]) + b) % DEPTH;
  endfunction

  function automatic void model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] old;
    if (!model.exists(idx) && s != 4'hF) return;
    old = model.exists(idx) ? model[idx] : 32'h0;
    for (int i = 0; i < 4; i++) if (s[i]) old[8*i +: 8] = d[8*i +: 8];
    model[idx] = old;
  endfunction

  task automatic do_write(input logic [31:0] addr, input int len, input logic [3:0] id);
    int t;
    bit to;
    to = 1'b0;
    awaddr = addr; awlen = {4'($urandom_range(0, 15)), 4'(len)}; awid = id;
    awsize = 3'd2; awvalid = 1'b1;
    t = 0; @(negedge clk);
    while (!awready && t < 50) begin @(negedge clk); t++; end
    if (!awready) to = 1'b1;
    @(posedge clk); #1; awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      wdata = wd[b]; wstrb = ws[b]; wlast = (b == len); wid = id; wvalid = 1'b1;
      t = 0; @(negedge clk);
      while (!wready && t < 100) begin @(negedge clk); t++; end
      if (!wready) to = 1'b1;
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    t = 0; @(negedge clk);
    while (!bvalid && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (to || bvalid !== 1'b1) begin
      errors++;
      $display("FAIL write_handshake addr=%h: got bvalid=%b timeout=%b required bvalid=1", addr, bvalid, to);
    end else begin
      checks++;
      if (bid !== id) begin errors++; $display("FAIL bid: got %h required %h", bid, id); end
      checks++;
      if (bresp !== 2'b00) begin errors++; $display("FAIL bresp: got %b required 00", bresp); end
    end
    @(posedge clk); #1; bready = 1'b0;
    if (!to) for (int b = 0; b <= len; b++) model_write(widx(addr, b), wd[b], ws[b]);
  endtask

  // mode: 0 rready held high, 1 toggling, 2 random
  task automatic do_read(input logic [31:0] addr, input int len, input logic [3:0] id, input int mode);
    int t, b, last_t, idx, gap;
    bit held, hl;
    logic [31:0] hd;
    araddr = addr; arlen = {4'($urandom_range(0, 15)), 4'(len)}; arid = id;
    arsize = 3'd2; arvalid = 1'b1;
    rready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    t = 0; @(negedge clk);
    while (!arready && t < 50) begin @(negedge clk); t++; end
    @(posedge clk); #1; arvalid = 1'b0;
    b = 0; t = 0; last_t = 0; held = 1'b0; hl = 1'b0; hd = '0;
    max_gap = 0; min_gap = 1000;
    while (b <= len && t < 400) begin
      @(negedge clk); t++;
      if (held) begin
        checks++;
        if (rvalid !== 1'b1 || rdata !== hd || rlast !== hl) begin
          errors++;
          $display("FAIL r_hold beat %0d: got v=%b d=%h l=%b required v=1 d=%h l=%b",
                   b, rvalid, rdata, rlast, hd, hl);
        end
        held = 1'b0;
      end
      if (rvalid === 1'b1) begin
        if (rready) begin
          idx = widx(addr, b);
          if (model.exists(idx)) begin
            checks++;
            if (rdata !== model[idx]) begin
              errors++;
              $display("FAIL rdata idx %0h beat %0d: got %h required %h", idx, b, rdata, model[idx]);
            end
          end
          checks++;
          if (rlast !== (b == len)) begin
            errors++;
            $display("FAIL rlast beat %0d: got %b required %b", b, rlast, (b == len));
          end
          checks++;
          if (rid !== id || rresp !== 2'b00) begin
            errors++;
            $display("FAIL rid_rresp: got %h/%b required %h/00", rid, rresp, id);
          end
          last_rdata = rdata;
          gap = t - last_t; last_t = t;
          if (gap > max_gap) max_gap = gap;
          if (gap < min_gap) min_gap = gap;
          b++;
        end else begin
          held = 1'b1; hd = rdata; hl = rlast;
        end
      end
      @(posedge clk); #1;
      case (mode)
        0:       rready = 1'b1;
        1:       rready = ~rready;
        default: rready = 1'($urandom_range(0, 1));
      endcase
    end
    rready = 1'b0;
    if (b <= len) begin
      checks++; errors++;
      $display("FAIL read_timeout addr=%h: got %0d beats required %0d", addr, b, len + 1);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL rst_arready: got %b required 1", arready); end
    checks++; if (awready !== 1'b1) begin errors++; $display("FAIL rst_awready: got %b required 1", awready); end
    checks++; if (rvalid !== 1'b0 || rlast !== 1'b0) begin errors++; $display("FAIL rst_rvalid_rlast: got %b%b required 00", rvalid, rlast); end
    checks++; if (rdata !== 32'h0 || rid !== 4'h0 || rresp !== 2'b00) begin errors++; $display("FAIL rst_rdata_rid: got %h/%h/%b required 0", rdata, rid, rresp); end
    checks++; if (wready !== 1'b0 || bvalid !== 1'b0) begin errors++; $display("FAIL rst_wready_bvalid: got %b%b required 00", wready, bvalid); end
    checks++; if (bid !== 4'h0 || bresp !== 2'b00) begin errors++; $display("FAIL rst_bid_bresp: got %h/%b required 0", bid, bresp); end
    @(posedge clk); #1; resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_rw();
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(32'h100, 0, 4'h1);
    do_read(32'h100, 0, 4'h0, 0);
    checks++;
    if (last_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata: got %h required deadbeef", last_rdata); end
    checks++;
    if (max_gap !== 3) begin errors++; $display("FAIL single_latency: got %0d required 3", max_gap); end
  endtask

  task automatic test_byte_merge();
    wd[0] = 32'h0000AA00; ws[0] = 4'b0010;
    do_write(32'h100, 0, 4'h3);
    do_read(32'h100, 0, 4'h4, 0);
    checks++;
    if (last_rdata !== 32'hDEADAAEF) begin errors++; $display("FAIL byte_merge: got %h required deadaaef", last_rdata); end
  endtask

  task automatic test_burst_backpressure();
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    do_write(32'h200, 3, 4'h2);
    do_read(32'h200, 3, 4'h7, 1);
    checks++;
    if (last_rdata !== 32'h4) begin errors++; $display("FAIL burst_last: got %h required 4", last_rdata); end
  endtask

  task automatic test_contention();
    for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(32'h400, 7, 4'h8);
    for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    fork
      do_write(32'h500, 7, 4'h5);
      do_read(32'h400, 7, 4'h6, 0);
    join
    checks++;
    if (max_gap > 4) begin errors++; $display("FAIL contention_read_wait: got gap %0d required <= 4", max_gap); end
    do_read(32'h500, 7, 4'h9, 0);
    checks++;
    if (max_gap !== 3 || min_gap !== 3) begin
      errors++; $display("FAIL burst_throughput: got gaps %0d..%0d required 3", min_gap, max_gap);
    end
  endtask

  task automatic test_raw();
    wd[0] = 32'h12345678; ws[0] = 4'hF;
    do_write(32'h300, 0, 4'hA);
    do_read(32'h300, 0, 4'hB, 0);
    checks++;
    if (last_rdata !== 32'h12345678) begin errors++; $display("FAIL read_after_write: got %h required 12345678", last_rdata); end
  endtask

  task automatic test_wrap();
    wd[0] = 32'hCAFE0001; ws[0] = 4'hF;
    wd[1] = 32'hCAFE0002; ws[1] = 4'hF;
    do_write(32'h0000FFFC, 1, 4'hC);
    do_read(32'h00010000, 0, 4'hD, 0);
    checks++;
    if (last_rdata !== 32'hCAFE0002) begin errors++; $display("FAIL addr_wrap: got %h required cafe0002", last_rdata); end
    do_read(32'h0000FFFC, 1, 4'hE, 2);
  endtask

  task automatic test_reset_mid_burst();
    int t;
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
    do_write(32'h600, 3, 4'h1);
    awaddr = 32'h600; awlen = 8'd3; awid = 4'h2; awvalid = 1'b1;
    t = 0; @(negedge clk);
    while (!awready && t < 50) begin @(negedge clk); t++; end
    @(posedge clk); #1; awvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      wdata = 32'hB0 + 32'(b); wstrb = 4'hF; wvalid = 1'b1;
      t = 0; @(negedge clk);
      while (!wready && t < 50) begin @(negedge clk); t++; end
      @(posedge clk); #1;
    end
    wdata = 32'hB2; resetn = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (awready !== 1'b1 || bvalid !== 1'b0 || wready !== 1'b0 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_burst: got awready=%b bvalid=%b wready=%b rvalid=%b required 1000",
               awready, bvalid, wready, rvalid);
    end
    resetn = 1'b1; wvalid = 1'b0;
    @(posedge clk); #1;
    model_write(widx(32'h600, 0), 32'hB0, 4'hF);
    model_write(widx(32'h600, 1), 32'hB1, 4'hF);
    do_read(32'h600, 3, 4'h3, 0);
    checks++;
    if (last_rdata !== 32'hA3) begin errors++; $display("FAIL reset_untouched: got %h required a3", last_rdata); end
  endtask

  task automatic test_random();
    logic [31:0] base;
    int len;
    for (int h = 0; h < 2; h++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      do_write(32'h1000 + 32'(h * 64), 15, 4'(h));
    end
    for (int it = 0; it < 24; it++) begin
      base = 32'h1000 + 32'($urandom_range(0, 15) * 4);
      len  = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        do_write(base, len, 4'($urandom));
      end else begin
        do_read(base, len, 4'($urandom), $urandom_range(0, 2));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_rw();
    test_byte_merge();
    test_burst_backpressure();
    test_contention();
    test_raw();
    test_wrap();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
